bus_port_fifo: RTL and testbench

- Per-terminal interface stage between one device and one port of the bs_gnrtr_n_rbtr bus.
- Feeds the bus: a TX FIFO presents pndng/D_pop to the bus and dequeues on pop.
- Consumes from the bus: an RX FIFO accepts push/D_push, filters packets by destination ID and queues them for the device.
- One instance per bus port. The bus-side pins map one-to-one onto a single index of the bus_if arrays.

---
 rtl/bus_port_fifo.sv | 129 ++++++++++++
 tb/tb_bus_port_fifo.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_port_fifo.sv
// bus_port_fifo: interface stage between one device and one port of the
// bs_gnrtr_n_rbtr bus.
//   TX path: device -> FIFO -> bus. First-word fall-through. D_pop shows the
//            head entry and pndng flags that the FIFO is non-empty. The bus
//            dequeues the head with pop.
//   RX path: bus -> ID filter -> FIFO -> device. Packets addressed to id or
//            bcast are queued. dev_rd_en returns the head entry one cycle
//            later on dev_rd_data, qualified by dev_rd_valid.
// Ports:
//   clk, reset                    rising-edge clock, synchronous active-high reset
//   dev_wr_en/dev_wr_data/dev_full        device side of the TX FIFO
//   pndng/D_pop/pop                       bus side of the TX FIFO
//   push/D_push                           bus side of the RX FIFO
//   dev_rd_en/dev_rd_data/dev_rd_valid/dev_empty  device side of the RX FIFO
//   tx_ovf_cnt, rx_drop_cnt, rx_misroute_cnt      saturating drop counters
module bus_port_fifo #(
  parameter int          pckg_sz = 16,
  parameter int          depth   = 8,
  parameter logic [7:0]  id      = 8'd0,
  parameter logic [7:0]  bcast   = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dev_wr_en,
  input  logic [pckg_sz-1:0] dev_wr_data,
  output logic               dev_full,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  input  logic               dev_rd_en,
  output logic [pckg_sz-1:0] dev_rd_data,
  output logic               dev_rd_valid,
  output logic               dev_empty,
  output logic [7:0]         tx_ovf_cnt,
  output logic [7:0]         rx_drop_cnt,
  output logic [7:0]         rx_misroute_cnt
);

  localparam int aw = $clog2(depth);

  // ---------------------------------------------------------------- TX FIFO
  logic [pckg_sz-1:0] tx_mem [depth];
  logic [aw:0]        tx_wr_ptr, tx_rd_ptr;
  logic               tx_empty, tx_full;
  logic               tx_do_pop, tx_do_wr, tx_ovf;

  // The extra MSB on each pointer tells full from empty when the indexes match.
  assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
  assign tx_full  = (tx_wr_ptr[aw] != tx_rd_ptr[aw]) &&
                    (tx_wr_ptr[aw-1:0] == tx_rd_ptr[aw-1:0]);

  // A pop in the same cycle frees the head slot, so a write while full can
  // still be taken. The popped word has already been read out through D_pop.
  assign tx_do_pop = !reset && pop && !tx_empty;
  assign tx_do_wr  = !reset && dev_wr_en && (!tx_full || tx_do_pop);
  assign tx_ovf    = !reset && dev_wr_en && tx_full && !tx_do_pop;

  assign pndng    = !tx_empty;
  assign D_pop    = tx_mem[tx_rd_ptr[aw-1:0]];
  assign dev_full = tx_full;

  always_ff @(posedge clk) begin
    if (tx_do_wr) tx_mem[tx_wr_ptr[aw-1:0]] <= dev_wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_ptr  <= '0;
      tx_rd_ptr  <= '0;
      tx_ovf_cnt <= '0;
    end else begin
      if (tx_do_wr)  tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_do_pop) tx_rd_ptr <= tx_rd_ptr + 1'b1;
      if (tx_ovf && tx_ovf_cnt != 8'hFF) tx_ovf_cnt <= tx_ovf_cnt + 8'd1;
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [pckg_sz-1:0] rx_mem [depth];
  logic [aw:0]        rx_wr_ptr, rx_rd_ptr;
  logic               rx_empty, rx_full;
  logic [7:0]         dest;
  logic               dest_ok;
  logic               rx_do_rd, rx_do_push, rx_drop, rx_misroute;

  assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
  assign rx_full  = (rx_wr_ptr[aw] != rx_rd_ptr[aw]) &&
                    (rx_wr_ptr[aw-1:0] == rx_rd_ptr[aw-1:0]);

  assign dest    = D_push[pckg_sz-1 -: 8];
  assign dest_ok = (dest == id) || (dest == bcast);

  // The head is copied to dev_rd_data on the same edge that the slot is
  // refilled, so a push and a read can both go ahead while the FIFO is full.
  assign rx_do_rd    = !reset && dev_rd_en && !rx_empty;
  assign rx_do_push  = !reset && push && dest_ok && (!rx_full || rx_do_rd);
  assign rx_drop     = !reset && push && dest_ok && rx_full && !rx_do_rd;
  assign rx_misroute = !reset && push && !dest_ok;

  assign dev_empty = rx_empty;

  always_ff @(posedge clk) begin
    if (rx_do_push) rx_mem[rx_wr_ptr[aw-1:0]] <= D_push;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wr_ptr       <= '0;
      rx_rd_ptr       <= '0;
      dev_rd_data     <= '0;
      dev_rd_valid    <= 1'b0;
      rx_drop_cnt     <= '0;
      rx_misroute_cnt <= '0;
    end else begin
      dev_rd_valid <= rx_do_rd;
      if (rx_do_rd) begin
        dev_rd_data <= rx_mem[rx_rd_ptr[aw-1:0]];
        rx_rd_ptr   <= rx_rd_ptr + 1'b1;
      end
      if (rx_do_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_drop && rx_drop_cnt != 8'hFF) rx_drop_cnt <= rx_drop_cnt + 8'd1;
      if (rx_misroute && rx_misroute_cnt != 8'hFF)
        rx_misroute_cnt <= rx_misroute_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_bus_port_fifo.sv
module tb_bus_port_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        dev_wr_en;
  logic [15:0] dev_wr_data;
  logic        dev_full;
  logic        pndng;
  logic [15:0] D_pop;
  logic        pop;
  logic        push;
  logic [15:0] D_push;
  logic        dev_rd_en;
  logic [15:0] dev_rd_data;
  logic        dev_rd_valid;
  logic        dev_empty;
  logic [7:0]  tx_ovf_cnt;
  logic [7:0]  rx_drop_cnt;
  logic [7:0]  rx_misroute_cnt;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  logic [15:0] tx_q [$];
  logic [15:0] rx_q [$];

  bus_port_fifo #(
    .pckg_sz(16),
    .depth  (8),
    .id     (8'd2),
    .bcast  (8'hFF)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .dev_wr_en      (dev_wr_en),
    .dev_wr_data    (dev_wr_data),
    .dev_full       (dev_full),
    .pndng          (pndng),
    .D_pop          (D_pop),
    .pop            (pop),
    .push           (push),
    .D_push         (D_push),
    .dev_rd_en      (dev_rd_en),
    .dev_rd_data    (dev_rd_data),
    .dev_rd_valid   (dev_rd_valid),
    .dev_empty      (dev_empty),
    .tx_ovf_cnt     (tx_ovf_cnt),
    .rx_drop_cnt    (rx_drop_cnt),
    .rx_misroute_cnt(rx_misroute_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tx_write(input logic [15:0] d, input bit accept);
    dev_wr_en   = 1'b1;
    dev_wr_data = d;
    if (accept) tx_q.push_back(d);
    tick();
    dev_wr_en = 1'b0;
  endtask

  // Checks the head against the scoreboard, then consumes it.
  task automatic tx_pop();
    logic [15:0] e;
    chk("tx_pndng_before_pop", pndng, 1);
    e = (tx_q.size() != 0) ? tx_q.pop_front() : 16'hxxxx;
    chk("tx_order", D_pop, e);
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic rx_push(input logic [15:0] d, input bit accept);
    push   = 1'b1;
    D_push = d;
    if (accept) rx_q.push_back(d);
    tick();
    push = 1'b0;
  endtask

  task automatic rx_read();
    logic [15:0] e;
    dev_rd_en = 1'b1;
    tick();
    dev_rd_en = 1'b0;
    e = (rx_q.size() != 0) ? rx_q.pop_front() : 16'hxxxx;
    chk("rx_valid", dev_rd_valid, 1);
    chk("rx_data", dev_rd_data, e);
  endtask

  initial begin
    reset = 1'b1; dev_wr_en = 1'b0; dev_wr_data = '0; pop = 1'b0;
    push = 1'b0; D_push = '0; dev_rd_en = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // reset state
    chk("rst_pndng", pndng, 0);
    chk("rst_dev_full", dev_full, 0);
    chk("rst_dev_empty", dev_empty, 1);
    chk("rst_rd_valid", dev_rd_valid, 0);
    chk("rst_rd_data", dev_rd_data, 0);
    chk("rst_tx_ovf", tx_ovf_cnt, 0);
    chk("rst_rx_drop", rx_drop_cnt, 0);
    chk("rst_rx_misroute", rx_misroute_cnt, 0);

    // TX basic: pndng one cycle after first write, FWFT head
    dev_wr_en = 1'b1; dev_wr_data = 16'h0301; tx_q.push_back(16'h0301);
    tick();
    chk("tx_pndng_latency", pndng, 1);
    chk("tx_first_head", D_pop, 16'h0301);
    tx_write(16'h0302, 1);
    tx_pop();
    tx_pop();
    chk("tx_pndng_drained", pndng, 0);

    // pop while empty: ignored
    pop = 1'b1; tick(); pop = 1'b0;
    chk("tx_pop_empty_pndng", pndng, 0);

    // Fill to full, one overflow
    for (int i = 1; i <= 8; i++) tx_write(16'h0100 + 16'(i), 1);
    chk("tx_full_after_8", dev_full, 1);
    tx_write(16'h0109, 0);
    chk("tx_ovf_one", tx_ovf_cnt, 1);
    for (int i = 0; i < 8; i++) tx_pop();
    chk("tx_empty_after_drain", pndng, 0);
    chk("tx_not_full_after_drain", dev_full, 0);

    // Refill across the pointer wrap, then saturate the overflow counter
    for (int i = 1; i <= 8; i++) tx_write(16'h0200 + 16'(i), 1);
    chk("tx_full_wrapped", dev_full, 1);
    for (int i = 0; i < 300; i++) tx_write(16'hDEAD, 0);
    chk("tx_ovf_saturate", tx_ovf_cnt, 255);

    // Pop and write together while full: both happen, stays full
    chk("tx_simul_head", D_pop, tx_q[0]);
    void'(tx_q.pop_front());
    tx_q.push_back(16'h0299);
    pop = 1'b1; dev_wr_en = 1'b1; dev_wr_data = 16'h0299;
    tick();
    pop = 1'b0; dev_wr_en = 1'b0;
    chk("tx_simul_full_stays", dev_full, 1);
    chk("tx_simul_no_ovf", tx_ovf_cnt, 255);
    for (int i = 0; i < 8; i++) tx_pop();
    chk("tx_empty_after_wrap", pndng, 0);

    // Pop and write together while empty: write accepted
    pop = 1'b1; dev_wr_en = 1'b1; dev_wr_data = 16'h0377; tx_q.push_back(16'h0377);
    tick();
    pop = 1'b0; dev_wr_en = 1'b0;
    chk("tx_simul_empty_pndng", pndng, 1);
    tx_pop();
    chk("tx_simul_empty_drained", pndng, 0);

    // RX filtering
    rx_push(16'h02AA, 1);
    rx_push(16'hFFBB, 1);
    rx_push(16'h05CC, 0);
    chk("rx_misroute_one", rx_misroute_cnt, 1);
    chk("rx_not_empty", dev_empty, 0);
    rx_read();
    rx_read();
    chk("rx_empty_after_reads", dev_empty, 1);

    // Read while empty: no valid, data held
    dev_rd_en = 1'b1; tick(); dev_rd_en = 1'b0;
    chk("rx_empty_read_valid", dev_rd_valid, 0);
    chk("rx_empty_read_hold", dev_rd_data, 16'hFFBB);
    tick();
    chk("rx_valid_idle", dev_rd_valid, 0);

    // RX full: simultaneous push + read both happen
    for (int i = 0; i < 8; i++) rx_push(16'h0210 + 16'(i), 1);
    rx_q.push_back(16'h02DD);
    push = 1'b1; D_push = 16'h02DD; dev_rd_en = 1'b1;
    tick();
    push = 1'b0; dev_rd_en = 1'b0;
    chk("rx_simul_valid", dev_rd_valid, 1);
    chk("rx_simul_data", dev_rd_data, rx_q.pop_front());
    chk("rx_simul_no_drop", rx_drop_cnt, 0);
    rx_push(16'h02EE, 0);
    chk("rx_drop_one", rx_drop_cnt, 1);
    rx_push(16'h07EE, 0);
    chk("rx_misroute_while_full", rx_misroute_cnt, 2);
    for (int i = 0; i < 3; i++) rx_read();

    // Simultaneous push and read on an empty RX: read returns nothing
    while (rx_q.size() != 0) rx_read();
    chk("rx_drained", dev_empty, 1);
    rx_q.push_back(16'hFF42);
    push = 1'b1; D_push = 16'hFF42; dev_rd_en = 1'b1;
    tick();
    push = 1'b0; dev_rd_en = 1'b0;
    chk("rx_simul_empty_valid", dev_rd_valid, 0);
    chk("rx_simul_empty_stored", dev_empty, 0);
    rx_read();

    // Reset with 5 entries in each FIFO, with pop/dev_rd_en asserted
    for (int i = 0; i < 5; i++) tx_write(16'h0400 + 16'(i), 1);
    for (int i = 0; i < 5; i++) rx_push(16'h0240 + 16'(i), 1);
    reset = 1'b1; pop = 1'b1; dev_rd_en = 1'b1;
    dev_wr_en = 1'b1; dev_wr_data = 16'h0BAD; push = 1'b1; D_push = 16'h0BAD;
    tick();
    reset = 1'b0; pop = 1'b0; dev_rd_en = 1'b0; dev_wr_en = 1'b0; push = 1'b0;
    tx_q.delete(); rx_q.delete();
    chk("mid_rst_pndng", pndng, 0);
    chk("mid_rst_dev_empty", dev_empty, 1);
    chk("mid_rst_dev_full", dev_full, 0);
    chk("mid_rst_rd_valid", dev_rd_valid, 0);
    chk("mid_rst_rd_data", dev_rd_data, 0);
    chk("mid_rst_tx_ovf", tx_ovf_cnt, 0);
    chk("mid_rst_rx_drop", rx_drop_cnt, 0);
    chk("mid_rst_rx_misroute", rx_misroute_cnt, 0);

    // Normal operation resumes from empty
    tx_write(16'h0501, 1);
    tx_pop();
    rx_push(16'h0255, 1);
    rx_read();
    chk("post_rst_tx_empty", pndng, 0);
    chk("post_rst_rx_empty", dev_empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
